// File: rtl/mem_row_mover_pkg.sv
// mem_row_mover_pkg: shared widths, FSM state encoding and job record for the row mover.
package mem_row_mover_pkg;
  localparam int CHWIDTH = 6;
  localparam int ADDRWIDTH = 17;
  localparam int COLWIDTH = 4;
  localparam int DWIDTH = 64;
  function automatic int beats(input int colw);
    return 1 << colw;
  endfunction
  localparam int BEATS = beats(COLWIDTH);
  typedef enum logic [2:0] {IDLE, AL_CMD, AL_WAIT, AL_WR, WB_RD, WB_CAP, WB_CMD, DONE} state_t;
  typedef struct packed {
    logic wb;
    logic [CHWIDTH-1:0] crow;
    logic [ADDRWIDTH-1:0] row;
  } job_t;
endpackage

// File: rtl/mem_row_mover_if.sv
// mem_row_mover_if: MEMSync job handshake, cache SRAM port and backing-store port.
interface mem_row_mover_if;
  import mem_row_mover_pkg::*;
  logic req_valid, req_wb, req_ready, sync, busy;
  logic [CHWIDTH-1:0] req_crow;
  logic [ADDRWIDTH-1:0] req_row;
  logic ca_en, ca_we;
  logic [CHWIDTH+COLWIDTH-1:0] ca_addr;
  logic [DWIDTH-1:0] ca_wdata, ca_rdata;
  logic bs_cmd_valid, bs_cmd_ready, bs_cmd_we, bs_rsp_valid;
  logic [ADDRWIDTH+COLWIDTH-1:0] bs_cmd_addr;
  logic [DWIDTH-1:0] bs_cmd_wdata, bs_rsp_data;
  modport master (
    output req_valid, req_wb, req_crow, req_row, ca_rdata, bs_cmd_ready, bs_rsp_valid, bs_rsp_data,
    input req_ready, sync, busy, ca_en, ca_we, ca_addr, ca_wdata, bs_cmd_valid, bs_cmd_we, bs_cmd_addr, bs_cmd_wdata
  );
  modport slave (
    input req_valid, req_wb, req_crow, req_row, ca_rdata, bs_cmd_ready, bs_rsp_valid, bs_rsp_data,
    output req_ready, sync, busy, ca_en, ca_we, ca_addr, ca_wdata, bs_cmd_valid, bs_cmd_we, bs_cmd_addr, bs_cmd_wdata
  );
endinterface

// File: rtl/mem_row_mover.sv
// mem_row_mover: moves one cache row to/from the backing store a beat at a time, pulsing sync when done.
module mem_row_mover
  import mem_row_mover_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mem_row_mover_if.slave bus
);
  state_t r_state, w_next;
  job_t r_job;
  logic [COLWIDTH-1:0] r_col;
  logic [DWIDTH-1:0] r_data;
  logic w_last;
  assign w_last = r_col == COLWIDTH'(BEATS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_job <= '0;
      r_col <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.req_valid) begin
        r_job <= {bus.req_wb, bus.req_crow, bus.req_row};
        r_col <= '0;
      end
      if (r_state == AL_WAIT && bus.bs_rsp_valid) r_data <= bus.bs_rsp_data;
      if (r_state == WB_CAP) r_data <= bus.ca_rdata;
      if ((r_state == AL_WR || (r_state == WB_CMD && bus.bs_cmd_ready)) && !w_last) r_col <= r_col + 1'b1;
      if (r_state == DONE) r_col <= '0;
    end
  end
  // Moore decode: every output depends only on state and registered job/col/data
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.req_valid ? (bus.req_wb ? WB_RD : AL_CMD) : IDLE;
      AL_CMD:  w_next = bus.bs_cmd_ready ? AL_WAIT : AL_CMD;
      AL_WAIT: w_next = bus.bs_rsp_valid ? AL_WR : AL_WAIT;
      AL_WR:   w_next = w_last ? DONE : AL_CMD;
      WB_RD:   w_next = WB_CAP;
      WB_CAP:  w_next = WB_CMD;
      WB_CMD:  w_next = bus.bs_cmd_ready ? (w_last ? DONE : WB_RD) : WB_CMD;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    bus.req_ready = r_state == IDLE;
    bus.busy = r_state != IDLE;
    bus.sync = r_state == DONE;
    bus.ca_en = r_state == AL_WR || r_state == WB_RD;
    bus.ca_we = r_state == AL_WR;
    bus.ca_addr = {r_job.crow, r_col};
    bus.ca_wdata = r_data;
    bus.bs_cmd_valid = r_state == AL_CMD || r_state == WB_CMD;
    bus.bs_cmd_we = r_state == WB_CMD;
    bus.bs_cmd_addr = {r_job.row, r_col};
    bus.bs_cmd_wdata = r_data;
  end
endmodule
